matmul_mem: RTL and testbench

Single-port word memory that serves the `matmul` request interface (`mem_req`/`mem_write`/`mem_addr`/`mem_wdata` → `mem_rdata_vld`/`mem_rdata`) with a fixed, parameterised read latency. It sits directly downstream of `matmul`, which sees it as its only memory. A secondary host port preloads A/B operands and reads back C results while `matmul` is idle. The whole block stalls with `sm_ena`, so returned read data stays in lock-step with the requesting state machine.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matmul_mem_array.sv | 30 +++
 rtl/matmul_mem.sv | 165 ++++++++++++++++
 tb/tb_matmul_mem.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul memory slice: read-latency bounds,
// request-source encoding and the read-pipeline stage record.
package matmul_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Data width carried by the pipeline stage record; the memory's MEM_DW must match.
    localparam int MM_DW = 32;

    typedef enum logic {
        SRC_MM   = 1'b0,
        SRC_HOST = 1'b1
    } rd_src_e;

    typedef struct packed {
        logic             vld;
        rd_src_e          src;
        logic [MM_DW-1:0] data;
    } rd_stage_t;

endpackage

// File: rtl/matmul_mem_array.sv
// Inferred single-port synchronous RAM with a registered read port.
// One access per enabled cycle; the read register holds between reads.
module matmul_mem_array #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_array [2**AW];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_array[addr] <= wdata;
            end else begin
                rdata_reg <= mem_array[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/matmul_mem.sv
// Word memory behind matmul: matmul port has priority over the host port,
// out-of-range accesses are flagged, and reads return after RD_LAT enabled cycles.
module matmul_mem
    import matmul_pkg::*;
#(
    parameter int MEM_AW     = 16,
    parameter int MEM_DW     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sm_ena,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    input  logic              host_req,
    input  logic              host_write,
    input  logic [MEM_AW-1:0] host_addr,
    input  logic [MEM_DW-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rdata_vld,
    output logic [MEM_DW-1:0] host_rdata,
    output logic              err_oor
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("matmul_mem: RD_LAT must be within 1..4");
    end
    if (DEPTH_LOG2 > MEM_AW) begin : g_bad_depth
        $error("matmul_mem: DEPTH_LOG2 must not exceed MEM_AW");
    end
    if (MEM_DW != MM_DW) begin : g_bad_dw
        $error("matmul_mem: MEM_DW must equal the pipeline stage data width");
    end

    logic              acc;
    logic              sel_write;
    logic              sel_oor;
    rd_src_e           sel_src;
    logic [MEM_AW-1:0] sel_addr;
    logic [MEM_DW-1:0] sel_wdata;
    logic              ram_en;
    logic [MEM_DW-1:0] ram_q;

    assign host_gnt = host_req & ~mem_req & sm_ena;
    assign acc      = sm_ena & (mem_req | host_req);

    always_comb begin
        sel_src   = SRC_HOST;
        sel_write = host_write;
        sel_addr  = host_addr;
        sel_wdata = host_wdata;
        if (mem_req) begin
            sel_src   = SRC_MM;
            sel_write = mem_write;
            sel_addr  = mem_addr;
            sel_wdata = mem_wdata;
        end
    end

    if (DEPTH_LOG2 < MEM_AW) begin : g_range
        assign sel_oor = |sel_addr[MEM_AW-1:DEPTH_LOG2];
    end else begin : g_full_range
        assign sel_oor = 1'b0;
    end

    // Out-of-range accesses never touch the array; the read result is forced to 0 downstream.
    assign ram_en = acc & ~sel_oor;

    matmul_mem_array #(
        .AW (DEPTH_LOG2),
        .DW (MEM_DW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (sel_write),
        .addr  (sel_addr[DEPTH_LOG2-1:0]),
        .wdata (sel_wdata),
        .rdata (ram_q)
    );

    // Stage 0 tags travel alongside the RAM's own output register.
    logic    s0_vld_reg;
    rd_src_e s0_src_reg;
    logic    s0_oor_reg;
    logic    err_oor_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_reg  <= 1'b0;
            s0_src_reg  <= SRC_MM;
            s0_oor_reg  <= 1'b0;
            err_oor_reg <= 1'b0;
        end else if (sm_ena) begin
            s0_vld_reg <= acc & ~sel_write;
            s0_src_reg <= sel_src;
            s0_oor_reg <= sel_oor;
            if (acc && sel_oor) begin
                err_oor_reg <= 1'b1;
            end
        end
    end

    rd_stage_t stage0;
    rd_stage_t stage [RD_LAT];

    always_comb begin
        stage0      = '0;
        stage0.vld  = s0_vld_reg;
        stage0.src  = s0_src_reg;
        stage0.data = s0_oor_reg ? '0 : ram_q;
    end

    assign stage[0] = stage0;

    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
        rd_stage_t stage_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_reg <= '0;
            end else if (sm_ena) begin
                stage_reg <= stage[gi-1];
            end
        end

        assign stage[gi] = stage_reg;
    end

    rd_stage_t         last_stage;
    logic              mem_vld_int;
    logic              host_vld_int;
    logic [MEM_DW-1:0] mem_hold_reg;
    logic [MEM_DW-1:0] host_hold_reg;

    assign last_stage   = stage[RD_LAT-1];
    assign mem_vld_int  = last_stage.vld & (last_stage.src == SRC_MM);
    assign host_vld_int = last_stage.vld & (last_stage.src == SRC_HOST);

    // Hold registers keep the last returned word visible between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_hold_reg  <= '0;
            host_hold_reg <= '0;
        end else if (sm_ena) begin
            if (mem_vld_int) begin
                mem_hold_reg <= last_stage.data;
            end
            if (host_vld_int) begin
                host_hold_reg <= last_stage.data;
            end
        end
    end

    assign mem_rdata_vld  = mem_vld_int;
    assign mem_rdata      = mem_vld_int ? last_stage.data : mem_hold_reg;
    assign host_rdata_vld = host_vld_int;
    assign host_rdata     = host_vld_int ? last_stage.data : host_hold_reg;
    assign err_oor        = err_oor_reg;

endmodule

// File: tb/tb_matmul_mem.sv
// Directed bench for matmul_mem (RD_LAT=2, DEPTH_LOG2=10): host access,
// streaming reads, arbitration, enable stall, out-of-range and mid-flight reset.
module tb_matmul_mem;

    logic        clk;
    logic        rst;
    logic        sm_ena;
    logic        mem_req;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdata_vld;
    logic [31:0] mem_rdata;
    logic        host_req;
    logic        host_write;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rdata_vld;
    logic [31:0] host_rdata;
    logic        err_oor;

    int checks = 0;
    int errors = 0;

    matmul_mem #(
        .MEM_AW     (16),
        .MEM_DW     (32),
        .DEPTH_LOG2 (10),
        .RD_LAT     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sm_ena         (sm_ena),
        .mem_req        (mem_req),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata_vld  (mem_rdata_vld),
        .mem_rdata      (mem_rdata),
        .host_req       (host_req),
        .host_write     (host_write),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_gnt       (host_gnt),
        .host_rdata_vld (host_rdata_vld),
        .host_rdata     (host_rdata),
        .err_oor        (err_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("check %-24s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        host_req   = 1'b0;
        host_write = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic host_wr(input logic [15:0] addr, input logic [31:0] data);
        host_req   = 1'b1;
        host_write = 1'b1;
        host_addr  = addr;
        host_wdata = data;
        step();
        host_req   = 1'b0;
        host_write = 1'b0;
    endtask

    task automatic mm_read_check(input string tag, input logic [15:0] addr, input logic [31:0] expected);
        mem_req   = 1'b1;
        mem_write = 1'b0;
        mem_addr  = addr;
        step();
        mem_req = 1'b0;
        check({tag, "_early_vld"}, {31'd0, mem_rdata_vld}, 32'd0);
        step();
        check({tag, "_vld"}, {31'd0, mem_rdata_vld}, 32'd1);
        check({tag, "_data"}, mem_rdata, expected);
        step();
    endtask

    initial begin
        rst    = 1'b1;
        sm_ena = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        check("reset_mem_vld", {31'd0, mem_rdata_vld}, 32'd0);
        check("reset_mem_rdata", mem_rdata, 32'd0);
        check("reset_host_vld", {31'd0, host_rdata_vld}, 32'd0);
        check("reset_host_rdata", host_rdata, 32'd0);
        check("reset_err_oor", {31'd0, err_oor}, 32'd0);

        // Host write then read of addr 5
        host_req   = 1'b1;
        host_write = 1'b1;
        host_addr  = 16'd5;
        host_wdata = 32'hDEADBEEF;
        #1;
        check("host_wr_gnt", {31'd0, host_gnt}, 32'd1);
        step();
        host_write = 1'b0;
        #1;
        check("host_rd_gnt", {31'd0, host_gnt}, 32'd1);
        step();
        host_req = 1'b0;
        check("host_rd_early_vld", {31'd0, host_rdata_vld}, 32'd0);
        step();
        check("host_rd_vld", {31'd0, host_rdata_vld}, 32'd1);
        check("host_rd_data", host_rdata, 32'hDEADBEEF);
        check("host_rd_mem_vld", {31'd0, mem_rdata_vld}, 32'd0);
        step();
        check("host_rd_vld_drop", {31'd0, host_rdata_vld}, 32'd0);
        check("host_rd_hold", host_rdata, 32'hDEADBEEF);

        // Preload and stream matmul reads
        host_wr(16'd0, 32'd10);
        host_wr(16'd1, 32'd20);
        host_wr(16'd2, 32'd30);
        host_wr(16'd3, 32'd40);
        for (int i = 0; i < 6; i++) begin
            mem_req   = (i < 4);
            mem_write = 1'b0;
            mem_addr  = 16'(i);
            step();
            if (i >= 1 && i <= 4) begin
                check($sformatf("stream_vld_%0d", i), {31'd0, mem_rdata_vld}, 32'd1);
                check($sformatf("stream_data_%0d", i), mem_rdata, 32'(i * 10));
            end else begin
                check($sformatf("stream_novld_%0d", i), {31'd0, mem_rdata_vld}, 32'd0);
            end
        end
        check("stream_hold", mem_rdata, 32'd40);
        idle_inputs();
        step();

        // Arbitration: host write to addr 7 waits for three matmul reads
        host_wr(16'd7, 32'h11);
        host_req   = 1'b1;
        host_write = 1'b1;
        host_addr  = 16'd7;
        host_wdata = 32'h77;
        for (int k = 0; k < 3; k++) begin
            mem_req   = 1'b1;
            mem_write = 1'b0;
            mem_addr  = 16'd0;
            #1;
            check($sformatf("arb_gnt_low_%0d", k), {31'd0, host_gnt}, 32'd0);
            step();
        end
        mem_req = 1'b0;
        #1;
        check("arb_gnt_high", {31'd0, host_gnt}, 32'd1);
        step();
        idle_inputs();
        step();
        step();
        mm_read_check("arb_readback", 16'd7, 32'h77);

        // Enable stall one cycle after a read accept
        mem_req  = 1'b1;
        mem_addr = 16'd1;
        step();
        mem_req = 1'b0;
        sm_ena  = 1'b0;
        host_req = 1'b1;
        #1;
        check("stall_host_gnt", {31'd0, host_gnt}, 32'd0);
        host_req = 1'b0;
        for (int s = 0; s < 4; s++) begin
            step();
            check($sformatf("stall_novld_%0d", s), {31'd0, mem_rdata_vld}, 32'd0);
        end
        sm_ena = 1'b1;
        step();
        check("stall_vld", {31'd0, mem_rdata_vld}, 32'd1);
        check("stall_data", mem_rdata, 32'd20);
        step();
        check("stall_no_dup", {31'd0, mem_rdata_vld}, 32'd0);

        // Out of range
        check("oor_before", {31'd0, err_oor}, 32'd0);
        mm_read_check("oor_read", 16'h0400, 32'd0);
        check("oor_flag", {31'd0, err_oor}, 32'd1);
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = 16'h0400;
        mem_wdata = 32'h00000BAD;
        step();
        idle_inputs();
        mm_read_check("oor_alias", 16'h0000, 32'd10);
        check("oor_sticky", {31'd0, err_oor}, 32'd1);

        // Reset one cycle after a read accept
        mem_req  = 1'b1;
        mem_addr = 16'd2;
        step();
        mem_req = 1'b0;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mem_vld", {31'd0, mem_rdata_vld}, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_host_vld", {31'd0, host_rdata_vld}, 32'd0);
        check("rst_host_rdata", host_rdata, 32'd0);
        check("rst_err_oor", {31'd0, err_oor}, 32'd0);
        step();
        check("rst_after_vld_1", {31'd0, mem_rdata_vld}, 32'd0);
        step();
        check("rst_after_vld_2", {31'd0, mem_rdata_vld}, 32'd0);
        check("rst_after_rdata", mem_rdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
